// File: rtl/instruction_memory_loader.sv
// rtl/instruction_memory_loader.sv - assembles UART bytes into 32-bit words and loads instruction memory
module instruction_memory_loader #(
  parameter int                  NB_DATA          = 32,
  parameter int                  NB_BYTE          = 8,
  parameter int                  NB_ADDR          = 10,
  parameter int                  NB_STATE         = 3,
  parameter logic [NB_BYTE-1:0]  CMD_LOAD         = 8'h4C,
  parameter logic [NB_DATA-1:0]  HALT_INSTRUCTION = 32'hFC00_0000
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  input  logic                i_rx_done,
  output logic                o_imem_write,
  output logic [NB_ADDR-1:0]  o_imem_addr,
  output logic [NB_DATA-1:0]  o_imem_data,
  output logic                o_loading,
  output logic                o_load_done,
  output logic                o_load_error,
  output logic [NB_ADDR:0]    o_word_count,
  output logic [NB_STATE-1:0] o_state
);

  typedef enum logic [NB_STATE-1:0] {
    S_IDLE    = NB_STATE'(0),
    S_RECEIVE = NB_STATE'(1),
    S_DONE    = NB_STATE'(2),
    S_ERROR   = NB_STATE'(3)
  } state_t;

  localparam logic [NB_ADDR-1:0] ADDR_MAX = '1;

  state_t                      state_q, state_d;
  logic [1:0]                  byte_idx_q;
  logic [NB_DATA-NB_BYTE-1:0]  shift_q;
  logic [NB_ADDR-1:0]          addr_q;
  logic [NB_ADDR:0]            count_q;
  logic [NB_DATA-1:0]          data_q;
  logic                        write_q;
  logic                        done_q;
  logic                        error_q;

  logic                        rx_cmd;
  logic                        rx_capture;
  logic                        word_last;
  logic                        start;
  logic [NB_DATA-1:0]          assembled;

  assign rx_cmd     = i_rx_done && (i_rx_data == CMD_LOAD);
  assign rx_capture = i_rx_done && (state_q == S_RECEIVE);
  assign word_last  = rx_capture && (byte_idx_q == 2'd3);
  assign assembled  = {shift_q, i_rx_data};
  assign start      = rx_cmd && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (rx_cmd) state_d = S_RECEIVE;
      S_RECEIVE: begin
        // Halt takes priority so a halt stored in the last slot still terminates cleanly
        if (word_last) begin
          if (assembled == HALT_INSTRUCTION) state_d = S_DONE;
          else if (addr_q == ADDR_MAX)       state_d = S_ERROR;
        end
      end
      S_DONE,
      S_ERROR:   if (rx_cmd) state_d = S_RECEIVE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      byte_idx_q <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      data_q     <= '0;
      write_q    <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= word_last;
      if (word_last) data_q <= assembled;

      if (start) begin
        byte_idx_q <= '0;
        addr_q     <= '0;
        count_q    <= '0;
        done_q     <= 1'b0;
        error_q    <= 1'b0;
      end else begin
        // Pointer advance retires the write issued last cycle; it saturates at the top slot
        if (write_q) begin
          count_q <= count_q + 1'b1;
          if (addr_q != ADDR_MAX) addr_q <= addr_q + 1'b1;
        end
        if (rx_capture) begin
          shift_q    <= assembled[NB_DATA-NB_BYTE-1:0];
          byte_idx_q <= byte_idx_q + 2'd1;
        end
        if (state_q == S_RECEIVE && state_d == S_DONE)  done_q  <= 1'b1;
        if (state_q == S_RECEIVE && state_d == S_ERROR) error_q <= 1'b1;
      end
    end
  end

  assign o_imem_write = write_q;
  assign o_imem_addr  = addr_q;
  assign o_imem_data  = data_q;
  assign o_loading    = (state_q == S_RECEIVE);
  assign o_load_done  = done_q;
  assign o_load_error = error_q;
  assign o_word_count = count_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// tb/tb_instruction_memory_loader.sv - directed self-checking bench for instruction_memory_loader
module tb_instruction_memory_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_done = 1'b0;

  logic        wr;
  logic [9:0]  addr;
  logic [31:0] data;
  logic        loading, done, err;
  logic [10:0] count;
  logic [2:0]  state;

  logic        wr2;
  logic [1:0]  addr2;
  logic [31:0] data2;
  logic        loading2, done2, err2;
  logic [2:0]  count2;
  logic [2:0]  state2;

  int checks = 0;
  int failures = 0;

  logic [9:0]  log_addr[$];
  logic [31:0] log_data[$];
  logic [1:0]  log2_addr[$];
  logic [31:0] log2_data[$];

  always #5 clk = ~clk;

  instruction_memory_loader dut (
    .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_imem_write(wr), .o_imem_addr(addr), .o_imem_data(data),
    .o_loading(loading), .o_load_done(done), .o_load_error(err),
    .o_word_count(count), .o_state(state)
  );

  instruction_memory_loader #(.NB_ADDR(2)) dut_small (
    .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_imem_write(wr2), .o_imem_addr(addr2), .o_imem_data(data2),
    .o_loading(loading2), .o_load_done(done2), .o_load_error(err2),
    .o_word_count(count2), .o_state(state2)
  );

  always @(negedge clk) begin
    if (wr) begin
      log_addr.push_back(addr);
      log_data.push_back(data);
    end
    if (wr2) begin
      log2_addr.push_back(addr2);
      log2_data.push_back(data2);
    end
  end

  task automatic clear_logs();
    log_addr.delete(); log_data.delete();
    log2_addr.delete(); log2_data.delete();
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; rx_done = 1'b0;
    @(negedge clk); rst = 1'b0;
    #1 clear_logs();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_done = 1'b1;
    @(negedge clk); rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if ({wr, addr, data, loading, done, err, count, state} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {wr, addr, data, loading, done, err, count, state});
    end
    @(negedge clk); rst = 1'b0;
    #1 clear_logs();
  endtask

  task automatic test_basic_load();
    do_reset();
    send_byte(8'h4C);
    checks++;
    if ({loading, state} !== {1'b1, 3'd1}) begin
      failures++; $display("FAIL cmd_enter_receive got=%b/%0d exp=1/1", loading, state);
    end
    send_word(32'h2008_0005);
    checks++;
    if ({wr, addr, data} !== {1'b1, 10'd0, 32'h2008_0005}) begin
      failures++; $display("FAIL word0_strobe got=%b/%0d/%h exp=1/0/20080005", wr, addr, data);
    end
    send_word(32'hFC00_0000);
    checks++;
    if ({wr, state, loading, done} !== {1'b1, 3'd2, 1'b0, 1'b1}) begin
      failures++; $display("FAIL halt_same_cycle got=%b/%0d/%b/%b exp=1/2/0/1", wr, state, loading, done);
    end
    settle();
    checks++;
    if (log_addr.size() != 2 || log_addr[0] !== 10'd0 || log_data[0] !== 32'h2008_0005 ||
        log_addr[1] !== 10'd1 || log_data[1] !== 32'hFC00_0000) begin
      failures++; $display("FAIL basic_writes got=%0d writes exp=2 (0:20080005 1:fc000000)", log_addr.size());
    end
    checks++;
    if ({done, err, count, loading} !== {1'b1, 1'b0, 11'd2, 1'b0}) begin
      failures++; $display("FAIL basic_final got=%b/%b/%0d/%b exp=1/0/2/0", done, err, count, loading);
    end
  endtask

  task automatic test_rearm();
    clear_logs();
    send_byte(8'h4C);
    checks++;
    if ({done, state, count} !== {1'b0, 3'd1, 11'd0}) begin
      failures++; $display("FAIL rearm_clear got=%b/%0d/%0d exp=0/1/0", done, state, count);
    end
    send_word(32'hFC00_0000);
    settle();
    checks++;
    if (log_addr.size() != 1 || log_addr[0] !== 10'd0 || log_data[0] !== 32'hFC00_0000) begin
      failures++; $display("FAIL rearm_write got=%0d writes exp=1 at addr 0", log_addr.size());
    end
    checks++;
    if ({count, done, state} !== {11'd1, 1'b1, 3'd2}) begin
      failures++; $display("FAIL rearm_final got=%0d/%b/%0d exp=1/1/2", count, done, state);
    end
  endtask

  task automatic test_ignore_before_cmd();
    do_reset();
    send_byte(8'h00); send_byte(8'h41); send_byte(8'hFF);
    settle();
    checks++;
    if (log_addr.size() != 0 || state !== 3'd0 || loading !== 1'b0) begin
      failures++; $display("FAIL ignore_pre_cmd got=%0d writes state=%0d exp=0 writes state=0", log_addr.size(), state);
    end
    send_byte(8'h4C);
    send_word(32'hFC00_0000);
    settle();
    checks++;
    if (log_addr.size() != 1 || log_addr[0] !== 10'd0 || log_data[0] !== 32'hFC00_0000 || state !== 3'd2) begin
      failures++; $display("FAIL ignore_then_load got=%0d writes state=%0d exp=1 write state=2", log_addr.size(), state);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    send_byte(8'h4C);
    send_word(32'h0102_0304);
    send_word(32'h0506_0708);
    send_word(32'h090A_0B0C);
    send_word(32'h0D0E_0F10);
    send_word(32'h1111_1111);
    settle();
    checks++;
    if (log2_addr.size() != 4) begin
      failures++; $display("FAIL overflow_write_count got=%0d exp=4", log2_addr.size());
    end else begin
      checks++;
      if (log2_addr[0] !== 2'd0 || log2_addr[1] !== 2'd1 || log2_addr[2] !== 2'd2 || log2_addr[3] !== 2'd3 ||
          log2_data[0] !== 32'h0102_0304 || log2_data[3] !== 32'h0D0E_0F10) begin
        failures++; $display("FAIL overflow_addrs got=%0d,%0d,%0d,%0d/%h exp=0,1,2,3/0d0e0f10",
                             log2_addr[0], log2_addr[1], log2_addr[2], log2_addr[3], log2_data[3]);
      end
    end
    checks++;
    if ({err2, done2, state2, count2, loading2} !== {1'b1, 1'b0, 3'd3, 3'd4, 1'b0}) begin
      failures++; $display("FAIL overflow_flags got=%b/%b/%0d/%0d/%b exp=1/0/3/4/0", err2, done2, state2, count2, loading2);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [8];
    seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_reset();
    send_byte(8'h4C);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); rx_data = seq[i]; rx_done = 1'b1;
    end
    @(negedge clk); rx_done = 1'b0;
    settle();
    checks++;
    if (log_addr.size() != 2 || log_addr[0] !== 10'd0 || log_data[0] !== 32'h1122_3344 ||
        log_addr[1] !== 10'd1 || log_data[1] !== 32'h5566_7788) begin
      failures++; $display("FAIL b2b_writes got=%0d writes exp=2 (0:11223344 1:55667788)", log_addr.size());
    end
    checks++;
    if ({count, state, addr} !== {11'd2, 3'd1, 10'd2}) begin
      failures++; $display("FAIL b2b_final got=%0d/%0d/%0d exp=2/1/2", count, state, addr);
    end
  endtask

  task automatic test_mid_word_reset();
    do_reset();
    send_word(32'h4C4C_4C4C);
    send_byte(8'h4C); send_byte(8'h12); send_byte(8'h34);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({wr, addr, data, loading, done, err, count, state} !== '0) begin
      failures++; $display("FAIL async_reset_outputs got=%h exp=0", {wr, addr, data, loading, done, err, count, state});
    end
    @(negedge clk); rst = 1'b0;
    #1 clear_logs();
    send_byte(8'h56); send_byte(8'h78);
    settle();
    checks++;
    if (log_addr.size() != 0 || state !== 3'd0 || wr !== 1'b0) begin
      failures++; $display("FAIL partial_discarded got=%0d writes state=%0d exp=0 writes state=0", log_addr.size(), state);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_rearm();
    test_ignore_before_cmd();
    test_overflow();
    test_back_to_back();
    test_mid_word_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_memory_loader.md
# instruction_memory_loader

Receives the program image byte-by-byte from the UART receiver, assembles 32-bit MIPS instruction words and writes them sequentially into instruction memory before execution starts. It sits directly downstream of the UART RX byte output (`o_data` / `o_rx_done_pulse`), in parallel with the debug receive command decoder. It holds the pipeline in load mode until the halt instruction has been stored.

## Interface

**Parameters**
- `NB_DATA`, 32: instruction word width.
- `NB_BYTE`, 8: UART byte width.
- `NB_ADDR`, 10: instruction memory word-address width.
- `NB_STATE`, 3: state register width.
- `CMD_LOAD`, 8'h4C: start-of-load command byte (`'L'`).
- `HALT_INSTRUCTION`, 32'hFC00_0000: halt opcode that terminates the image.

**Ports**
- `i_clock`, in, 1: system clock. All state changes occur on the rising edge.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `i_rx_data`, in, `NB_BYTE`: last byte received by the UART.
- `i_rx_done`, in, 1: single-cycle pulse; `i_rx_data` is valid in the same cycle.
- `o_imem_write`, out, 1: single-cycle write strobe to instruction memory.
- `o_imem_addr`, out, `NB_ADDR`: word address for the write.
- `o_imem_data`, out, `NB_DATA`: assembled word for the write.
- `o_loading`, out, 1: high while in RECEIVE. Holds the CPU in reset/stall.
- `o_load_done`, out, 1: level; the image is stored and terminated by the halt instruction.
- `o_load_error`, out, 1: level; memory filled before the halt instruction arrived.
- `o_word_count`, out, `NB_ADDR+1`: number of words written in the current load.
- `o_state`, out, `NB_STATE`: current state.

## Operation

**State encoding:** IDLE=0, RECEIVE=1, DONE=2, ERROR=3. All other encodings return to IDLE on the next clock.

**IDLE**
- `i_rx_done` with `i_rx_data == CMD_LOAD`: go to RECEIVE; clear the byte index, address and `o_word_count`.
- Any other byte is ignored.

**RECEIVE** (per `i_rx_done`)
- The byte is shifted into the assembly register, MSB first: byte 0 → bits [31:24], byte 3 → bits [7:0].
- The 2-bit byte index increments and wraps 3→0.
- On byte 3:
  - Next cycle: `o_imem_write`=1 with `o_imem_data` = the full word and `o_imem_addr` = the current address.
  - After that write: address +1 and `o_word_count` +1.
- Assembled word == `HALT_INSTRUCTION`: the word is still written, then next state is DONE.
- Otherwise, if the written address was 2^NB_ADDR−1: next state is ERROR. The address does not wrap and nothing is ever written to address 0 twice.

**DONE / ERROR**
- Outputs hold.
- `i_rx_done` with `CMD_LOAD` re-arms the loader: go to RECEIVE and clear address, count, index, `o_load_done` and `o_load_error`.
- Other bytes are ignored.

**Flag behaviour**
- `o_load_done` sets on entry to DONE.
- `o_load_error` sets on entry to ERROR.
- The two flags are mutually exclusive.

**Command byte inside RECEIVE:** a `CMD_LOAD` byte received in RECEIVE is treated as data, not as a restart.

## Timing

**Reset values:** state=IDLE, `o_imem_write`=0, `o_imem_addr`=0, `o_imem_data`=0, `o_loading`=0, `o_load_done`=0, `o_load_error`=0, `o_word_count`=0.

**Latencies**
- `CMD_LOAD` pulse at edge N → `o_loading`=1 and `o_state`=1 after edge N.
- Byte-3 pulse captured at edge N → `o_imem_write` high for exactly the cycle after edge N. Address and data are stable throughout that cycle.
- Halt word → `o_imem_write` pulse and the DONE state become visible in the same cycle. `o_loading` falls in that same cycle.

**Concurrency**
- An `i_rx_done` coinciding with the `o_imem_write` cycle is captured as byte 0 of the next word. No byte is lost.
- The address/count update and the byte capture happen in the same edge.

**Mid-operation reset:** asynchronous reset at any time forces all outputs to their reset values immediately. A partial word is discarded.

**Back-to-back pulses:** consecutive `i_rx_done` pulses (one per cycle) are all accepted.

## Test plan

1. **Basic load:** reset, then send bytes 4C, 20,08,00,05, FC,00,00,00.
   - Writes: addr 0 = 32'h2008_0005, addr 1 = 32'hFC00_0000.
   - Afterwards: `o_load_done`=1, `o_word_count`=2, `o_loading`=0.
2. **Ignore before command:** send 00, 41, FF, then 4C, FC,00,00,00.
   - No write occurs before 4C.
   - Exactly one write, to addr 0; then DONE.
3. **Overflow:** NB_ADDR=2; send 4C plus 4 non-halt words.
   - 4 writes to addr 0..3.
   - `o_load_error`=1, `o_load_done`=0, state=3; no fifth write.
4. **Back-to-back bytes:** pulse `i_rx_done` on 8 consecutive cycles after 4C.
   - Two correct writes.
   - The byte coinciding with the first write strobe lands in bits [31:24] of word 1.
5. **Mid-word reset:** after 4C, 12, 34, assert `i_reset` for 1 cycle.
   - All outputs are 0 and state is IDLE.
   - Subsequent 56, 78 produce no write.
6. **Re-arm from DONE:** complete scenario 1, then send 4C, FC,00,00,00.
   - `o_load_done` clears on 4C.
   - Write to addr 0; `o_word_count`=1; DONE again.
